// File: rtl/riscv_wb_pkg.sv
// Shared encodings for the memory/writeback stage: writeback source select,
// load funct3 values, stage FSM states and the default datapath width.
// Imported by load_align and mem_wb_stage.
package riscv_wb_pkg;

    localparam int XLEN_DEFAULT = 32;

    // Writeback result source (ex_wb_sel)
    localparam logic [1:0] WB_ALU  = 2'b00;
    localparam logic [1:0] WB_LOAD = 2'b01;
    localparam logic [1:0] WB_PC4  = 2'b10;
    localparam logic [1:0] WB_RSVD = 2'b11;

    // Load type (ex_funct3)
    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        WAIT_LD = 2'd1,
        COMMIT  = 2'd2
    } wb_state_t;

endpackage

// File: rtl/mem_wb_stage_load_align.sv
// load_align: extracts and extends a byte/halfword/word load from an aligned
// memory word, and flags misaligned or illegal load types. Purely combinational.
// Ports: funct3_i, addr_i (byte offset), word_i -> data_o, misaligned_o, illegal_o.
module load_align
    import riscv_wb_pkg::*;
#(
    parameter int XLEN = XLEN_DEFAULT
) (
    input  logic [2:0]      funct3_i,
    input  logic [1:0]      addr_i,
    input  logic [XLEN-1:0] word_i,
    output logic [XLEN-1:0] data_o,
    output logic            misaligned_o,
    output logic            illegal_o
);

    logic [7:0]  byte_v;
    logic [15:0] half_v;

    always_comb begin
        byte_v       = word_i[{addr_i, 3'b000} +: 8];
        half_v       = addr_i[1] ? word_i[16 +: 16] : word_i[0 +: 16];
        data_o       = '0;
        misaligned_o = 1'b0;
        illegal_o    = 1'b0;
        case (funct3_i)
            F3_LB:  data_o = {{(XLEN-8){byte_v[7]}}, byte_v};
            F3_LBU: data_o = {{(XLEN-8){1'b0}}, byte_v};
            F3_LH: begin
                data_o       = {{(XLEN-16){half_v[15]}}, half_v};
                misaligned_o = addr_i[0];
            end
            F3_LHU: begin
                data_o       = {{(XLEN-16){1'b0}}, half_v};
                misaligned_o = addr_i[0];
            end
            F3_LW: begin
                data_o       = word_i;
                misaligned_o = |addr_i;
            end
            default: illegal_o = 1'b1;
        endcase
    end

endmodule

// File: rtl/mem_wb_stage.sv
// mem_wb_stage: memory/writeback stage feeding the register-file write port.
// Ports: EX/MEM capture (ex_*), load response (dmem_rsp_*), register-file write
// (rg_wrt_*), error pulse (wb_err), bypass (fwd_*; live only with WB_FWD_EN defined).
module mem_wb_stage
    import riscv_wb_pkg::*;
#(
    parameter int XLEN   = XLEN_DEFAULT,
    parameter int REG_AW = 5
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              flush,
    input  logic              ex_valid,
    output logic              ex_ready,
    input  logic              ex_reg_write,
    input  logic [REG_AW-1:0] ex_rd,
    input  logic [1:0]        ex_wb_sel,
    input  logic [2:0]        ex_funct3,
    input  logic [XLEN-1:0]   ex_alu_result,
    input  logic [XLEN-1:0]   ex_pc_plus4,
    input  logic              dmem_rsp_valid,
    input  logic [XLEN-1:0]   dmem_rsp_data,
    output logic              rg_wrt_en,
    output logic [REG_AW-1:0] rg_wrt_addr,
    output logic [XLEN-1:0]   rg_wrt_data,
    output logic              wb_err,
    output logic              fwd_valid,
    output logic [REG_AW-1:0] fwd_rd,
    output logic [XLEN-1:0]   fwd_data
);

    wb_state_t         state_q, state_d;
    logic              reg_write_q, reg_write_d;
    logic [REG_AW-1:0] rd_q, rd_d;
    logic [2:0]        funct3_q, funct3_d;
    logic [1:0]        addr_q, addr_d;
    logic [XLEN-1:0]   res_q, res_d;
    logic              err_q, err_d;
    // Last committed write, so the port holds steady while rg_wrt_en is low.
    logic [REG_AW-1:0] hold_addr_q;
    logic [XLEN-1:0]   hold_data_q;

    logic              accept;
    logic [XLEN-1:0]   ld_data;
    logic              ld_misaligned;
    logic              ld_illegal;

    load_align #(.XLEN(XLEN)) u_load_align (
        .funct3_i     (funct3_q),
        .addr_i       (addr_q),
        .word_i       (dmem_rsp_data),
        .data_o       (ld_data),
        .misaligned_o (ld_misaligned),
        .illegal_o    (ld_illegal)
    );

    // Not ready while reset is held so nothing is accepted into a clearing stage.
    assign ex_ready = reset && !flush && (state_q == IDLE || state_q == COMMIT);
    assign accept   = ex_valid && ex_ready;

    assign rg_wrt_en   = reset && (state_q == COMMIT) && reg_write_q &&
                         (rd_q != '0) && !err_q && !flush;
    assign rg_wrt_addr = rg_wrt_en ? rd_q  : hold_addr_q;
    assign rg_wrt_data = rg_wrt_en ? res_q : hold_data_q;
    // err_q is only ever set for a single cycle, which makes this a pulse.
    assign wb_err      = err_q;

`ifdef WB_FWD_EN
    assign fwd_valid = rg_wrt_en;
    assign fwd_rd    = rg_wrt_addr;
    assign fwd_data  = rg_wrt_data;
`else
    assign fwd_valid = 1'b0;
    assign fwd_rd    = '0;
    assign fwd_data  = '0;
`endif

    always_comb begin
        state_d     = state_q;
        reg_write_d = reg_write_q;
        rd_d        = rd_q;
        funct3_d    = funct3_q;
        addr_d      = addr_q;
        res_d       = res_q;
        err_d       = 1'b0;
        case (state_q)
            IDLE, COMMIT: begin
                state_d = IDLE;
                if (accept) begin
                    reg_write_d = ex_reg_write;
                    rd_d        = ex_rd;
                    funct3_d    = ex_funct3;
                    addr_d      = ex_alu_result[1:0];
                    case (ex_wb_sel)
                        WB_ALU: begin
                            res_d   = ex_alu_result;
                            state_d = COMMIT;
                        end
                        WB_PC4: begin
                            res_d   = ex_pc_plus4;
                            state_d = COMMIT;
                        end
                        WB_LOAD: state_d = WAIT_LD;
                        default: begin
                            reg_write_d = 1'b0;
                            err_d       = 1'b1;
                            state_d     = IDLE;
                        end
                    endcase
                end
            end
            WAIT_LD: begin
                if (dmem_rsp_valid) begin
                    res_d   = ld_data;
                    err_d   = ld_misaligned || ld_illegal;
                    state_d = COMMIT;
                end
            end
            default: state_d = IDLE;
        endcase
        // A flush discards whatever is in flight, including a same-cycle response.
        if (flush) begin
            state_d = IDLE;
            err_d   = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q     <= IDLE;
            reg_write_q <= 1'b0;
            rd_q        <= '0;
            funct3_q    <= '0;
            addr_q      <= '0;
            res_q       <= '0;
            err_q       <= 1'b0;
            hold_addr_q <= '0;
            hold_data_q <= '0;
        end else begin
            state_q     <= state_d;
            reg_write_q <= reg_write_d;
            rd_q        <= rd_d;
            funct3_q    <= funct3_d;
            addr_q      <= addr_d;
            res_q       <= res_d;
            err_q       <= err_d;
            if (rg_wrt_en) begin
                hold_addr_q <= rd_q;
                hold_data_q <= res_q;
            end
        end
    end

endmodule
